// File: rtl/alarm_notification_dispatcher.sv
// Debounces the health controller's severity code, then runs the caregiver
// req/ack notification with retry gaps, escalation buzzer and severity upgrades.
module alarm_notification_dispatcher #(
  parameter int CONFIRM_CYCLES   = 3,
  parameter int ACK_TIMEOUT      = 16,
  parameter int MAX_RETRIES      = 2,
  parameter int BUZZ_HALF_PERIOD = 4
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [2:0] abnormalityWarning,
  input  logic       caregiverAck,
  input  logic       clearAlarm,
  output logic       notifyRequest,
  output logic [2:0] notifySeverity,
  output logic       alarmActive,
  output logic       escalated,
  output logic       buzzer
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BW = $clog2(BUZZ_HALF_PERIOD + 1);

  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [BW-1:0] BUZZ_LAST    = BW'(BUZZ_HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE, CONFIRM, NOTIFY, GAP, ESCALATED, ACKED
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [BW-1:0] buzzCnt_q, buzzCnt_d;
  logic [2:0]    sev_q, sev_d;
  logic          req_q, req_d;
  logic          active_q, active_d;
  logic          esc_q, esc_d;
  logic          buzz_q, buzz_d;
  logic [CW-1:0] cntNext;
  logic          upgrade;

  assign upgrade = abnormalityWarning > sev_q;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    count_d   = count_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    buzzCnt_d = '0;
    sev_d     = sev_q;
    buzz_d    = 1'b0;
    cntNext   = CW'(1);

    case (state_q)
      IDLE: begin
        if (abnormalityWarning != 3'd0) begin
          cand_d  = abnormalityWarning;
          count_d = CW'(1);
          if (CONFIRM_CYCLES == 1) begin
            state_d   = NOTIFY;
            sev_d     = abnormalityWarning;
            count_d   = '0;
            timer_d   = '0;
            retries_d = '0;
          end else begin
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (abnormalityWarning == 3'd0) begin
          state_d = IDLE;
          cand_d  = 3'd0;
          count_d = '0;
        end else begin
          cntNext = (abnormalityWarning == cand_q) ? count_q + CW'(1) : CW'(1);
          cand_d  = abnormalityWarning;
          count_d = cntNext;
          if (cntNext == CONFIRM_LAST) begin
            state_d   = NOTIFY;
            sev_d     = abnormalityWarning;
            count_d   = '0;
            timer_d   = '0;
            retries_d = '0;
          end
        end
      end
      NOTIFY: begin
        // Upgrade outranks ack, and ack outranks timeout on the same edge.
        if (upgrade) begin
          sev_d   = abnormalityWarning;
          timer_d = '0;
        end else if (caregiverAck) begin
          state_d = ACKED;
        end else if (timer_q == TIMER_LAST) begin
          if (retries_q < RETRY_MAX) begin
            state_d   = GAP;
            retries_d = retries_q + RW'(1);
          end else begin
            state_d = ESCALATED;
            buzz_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        state_d = NOTIFY;
        timer_d = '0;
        if (upgrade) sev_d = abnormalityWarning;
      end
      ESCALATED: begin
        if (buzzCnt_q == BUZZ_LAST) begin
          buzz_d    = ~buzz_q;
          buzzCnt_d = '0;
        end else begin
          buzz_d    = buzz_q;
          buzzCnt_d = buzzCnt_q + BW'(1);
        end
        if (upgrade) begin
          sev_d = abnormalityWarning;
        end else if (caregiverAck) begin
          state_d   = ACKED;
          buzz_d    = 1'b0;
          buzzCnt_d = '0;
        end
      end
      ACKED: begin
        if (upgrade) begin
          state_d   = NOTIFY;
          sev_d     = abnormalityWarning;
          timer_d   = '0;
          retries_d = '0;
        end else if (clearAlarm && abnormalityWarning == 3'd0) begin
          state_d   = IDLE;
          sev_d     = 3'd0;
          timer_d   = '0;
          retries_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d    = (state_d == NOTIFY) || (state_d == ESCALATED);
    active_d = (state_d != IDLE) && (state_d != CONFIRM);
    esc_d    = (state_d == ESCALATED);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cand_q    <= 3'd0;
      count_q   <= '0;
      timer_q   <= '0;
      retries_q <= '0;
      buzzCnt_q <= '0;
      sev_q     <= 3'd0;
      req_q     <= 1'b0;
      active_q  <= 1'b0;
      esc_q     <= 1'b0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      buzzCnt_q <= buzzCnt_d;
      sev_q     <= sev_d;
      req_q     <= req_d;
      active_q  <= active_d;
      esc_q     <= esc_d;
      buzz_q    <= buzz_d;
    end
  end

  assign notifyRequest  = req_q;
  assign notifySeverity = sev_q;
  assign alarmActive    = active_q;
  assign escalated      = esc_q;
  assign buzzer         = buzz_q;

endmodule

// File: doc/alarm_notification_dispatcher.md
Name: alarm_notification_dispatcher

Overview:
Downstream consumer of the health controller's 3-bit abnormalityWarning code, where 0 means normal and 1..7 is increasing severity. It debounces the code, latches a confirmed severity, and raises a req/ack notification to the caregiver link. Unacknowledged alarms are retried and then escalated with a pulsed buzzer. Upgrades in severity are tracked while an alarm is open.

Parameters:
CONFIRM_CYCLES, 3, consecutive identical nonzero samples needed to confirm (>=1)
ACK_TIMEOUT, 16, cycles notifyRequest stays high per attempt before timeout (>=2)
MAX_RETRIES, 2, retry gaps allowed before escalation
BUZZ_HALF_PERIOD, 4, buzzer high/low phase length in cycles

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
abnormalityWarning  input  3  severity code from health controller
caregiverAck  input  1  caregiver acknowledge, sampled level
clearAlarm  input  1  operator clear request, sampled level
notifyRequest  output  1  notification request to caregiver link
notifySeverity  output  3  latched confirmed severity
alarmActive  output  1  alarm open (confirmed, not yet cleared)
escalated  output  1  retries exhausted
buzzer  output  1  local buzzer drive

Behaviour:
- Reset: asynchronous, active-low, effective immediately without a clock edge. Forces IDLE. All outputs 0. Candidate, latched severity, confirm counter, timer and retry counter all 0.
- States: IDLE, CONFIRM, NOTIFY, GAP, ESCALATED, ACKED. All outputs are registered.
- IDLE: all outputs 0. A nonzero warning moves to CONFIRM with candidate = warning and count = 1.
- CONFIRM:
  - Warning == 0: go to IDLE.
  - Nonzero warning different from candidate: candidate = new value, count = 1.
  - Equal warning: count increments.
  - When count reaches CONFIRM_CYCLES, on that same edge: go to NOTIFY, notifySeverity = candidate, notifyRequest = 1, alarmActive = 1, timer = 0, retries = 0.
  - With CONFIRM_CYCLES = 1, NOTIFY is entered on the first nonzero sample.
- NOTIFY: notifyRequest is held for exactly ACK_TIMEOUT cycles. Each edge is evaluated in this priority order:
  1. Warning > notifySeverity: notifySeverity = warning, timer = 0, retries unchanged. This beats a simultaneous ack.
  2. caregiverAck = 1: go to ACKED. This beats a simultaneous timeout.
  3. Timeout with retries < MAX_RETRIES: go to GAP, retries++.
  4. Timeout with retries == MAX_RETRIES: go to ESCALATED.
- GAP: notifyRequest = 0 for exactly one cycle, then back to NOTIFY with timer = 0. Ack is ignored in GAP. A severity upgrade during GAP is latched and returns to NOTIFY.
- ESCALATED:
  - escalated = 1 and notifyRequest = 1.
  - buzzer = 1 on entry, then toggles every BUZZ_HALF_PERIOD cycles.
  - A severity upgrade updates notifySeverity and keeps the state.
  - Ack goes to ACKED.
  - There is no further timeout.
- ACKED: notifyRequest, escalated and buzzer are 0; alarmActive stays 1.
  - Warning > notifySeverity: go to NOTIFY with the new severity, retries = 0, timer = 0.
  - clearAlarm = 1 with warning == 0: go to IDLE, notifySeverity = 0, alarmActive = 0.
  - clearAlarm with a nonzero warning is ignored.
- clearAlarm is ignored in every state except ACKED.
- notifySeverity never decreases while alarmActive = 1. A lower or zero warning is ignored.
- The timer is wide enough for ACK_TIMEOUT and does not wrap. Retries saturate at MAX_RETRIES.
- With MAX_RETRIES = 0, the first timeout escalates directly and no GAP occurs.

Test Plan (default parameters; E0 is the edge where notifyRequest rises):
- Glitch rejection: warning=5 for 2 edges, then 0 -> notifyRequest and alarmActive never assert; state returns to IDLE.
- Confirm/ack/clear:
  - warning=3 held 3 edges -> notifyRequest=1 and notifySeverity=3 at 3rd edge.
  - Ack at E0+5 -> notifyRequest=0 and alarmActive=1 after that edge.
  - warning=0 plus clearAlarm -> alarmActive=0, notifySeverity=0.
- Retry/escalation, no ack:
  - notifyRequest high E0..E0+15, low at E0+16, high E0+17..E0+32, low at E0+33, high E0+34..E0+49.
  - At E0+50: escalated=1, buzzer pattern 1,1,1,1,0,0,0,0.
  - Ack -> escalated=0, buzzer=0.
- Upgrade and priority:
  - Confirmed severity 2, then warning=6 for one cycle -> notifySeverity=6, timer restarts.
  - warning=1 -> notifySeverity stays 6.
  - Ack on the same edge as an upgrade to 7 -> stays NOTIFY with notifySeverity=7.
  - Ack on the timeout edge -> ACKED with no gap.
- Clear blocking: clearAlarm in NOTIFY, or in ACKED with warning=4 -> ignored, alarmActive stays 1.
- Async reset: drop resetN mid-ESCALATED, between clock edges -> all outputs 0 immediately; after release, warning=0 keeps IDLE.
